mc_core: RTL
============

# mc_core

Parametrised multi-cycle successor to the single-cycle sample processor top. It contains the PC, instruction register, register file, ALU flags and a fetch/execute/memory state machine. The 4-bit opcode set carries over. Data memory sits behind a req/ack handshake, so memory may take any number of cycles. The block is started explicitly and reports `done` on HALT.

## Interface
Parameters:
- `DW`, 8: data/register width.
- `RAW`, 4: register address width (2^RAW registers). Instruction width `IW` = 1+4+RAW.
- `PCW`, 16: program counter width.

Ports:
- `clk`  in  1  clock. All state is updated on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that leaves IDLE or HALTED and begins fetching at PC 0.
- `imem_addr`  out  PCW  instruction address; equals PC.
- `imem_data`  in  IW  instruction from a combinational ROM.
- `dmem_req`  out  1  data memory request. Held until `dmem_ack`.
- `dmem_we`  out  1  1 = store, 0 = load. Stable while `dmem_req` is high.
- `dmem_addr`  out  DW  data memory address.
- `dmem_wdata`  out  DW  store data.
- `dmem_rdata`  in  DW  load data. Valid in the cycle `dmem_ack` is high.
- `dmem_ack`  in  1  completion. Single cycle; only honoured while `dmem_req` is high.
- `done`  out  1  high while in HALTED.
- `instr_count`  out  32  number of retired instructions since the last `start`. Saturates at all-ones.

## Operation
- Instruction fields: `f` = bit IW-1, `op` = bits IW-2:RAW, `rt` = bits RAW-1:0. rs is always r0 (the accumulator).
- Opcodes:
  - 0 ADC: rt = rt + r0 + C. C = carry-out.
  - 1 SBB: rt = rt - r0 - C. C = borrow.
  - 2 AND, 3 OR, 4 XOR: C unchanged.
  - 5 SHL: C = old msb.
  - 6 SHR: C = old lsb.
  - 7 MOV: rt = r0.
  - 8 MVA: r0 = rt.
  - 9 CLR: C = 0. No register write.
  - A BZ, B BNZ: if condition on Z is true, PC = PC + sign-extended rt value; otherwise PC+1.
  - C LD: r0 = mem[rt].
  - D ST: mem[rt] = r0.
  - E JMP: PC = PC - zero-extended rt value.
  - F NOP.
- `f`=1 on ops 0-8 suppresses the register write. Flags still update, which gives compare/test.
- HALT is the all-ones instruction. It takes precedence over op F.
- Z is updated by ops 0-8 only. It is 1 when the DW-bit result is zero.
- Arithmetic is modulo 2^DW. PC arithmetic is modulo 2^PCW, so a branch wraps across 0.
- States:
  - IDLE: after reset.
  - FETCH: IR = `imem_data`, go to EXEC.
  - EXEC:
    - ALU ops, branches, CLR and NOP retire and return to FETCH.
    - LD/ST raise `dmem_req` and go to MEM.
    - HALT goes to HALTED with PC held.
  - MEM: wait for `dmem_ack`, then retire (the LD writes r0) and return to FETCH.
  - HALTED: holds `done` high.
- `start` is only honoured in IDLE or HALTED. It sets PC to 0, clears C, Z and `instr_count`, and goes to FETCH. Register contents are preserved.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE; PC, C, Z and `instr_count` = 0.
  - All registers = 0.
  - `dmem_req`, `dmem_we`, `done` = 0; `dmem_addr`, `dmem_wdata` = 0.
- Reset during MEM drops `dmem_req` in the same cycle. An ack arriving after that is ignored.
- Cycle counts: ALU, branch, CLR and NOP take 2 cycles. LD/ST take 2 + N, where N ≥ 1 is the number of cycles from the `dmem_req` rise up to and including the ack cycle. HALT takes 2 cycles to reach `done`.
- `dmem_req` rises on the edge that leaves EXEC and falls on the edge after `dmem_ack`.
- `dmem_addr`, `dmem_we` and `dmem_wdata` are registered and stable while `dmem_req` is high.
- `instr_count` increments on the retiring edge. HALT is not counted.
- `start` outside IDLE/HALTED is ignored. `start` and reset together: reset wins.
- `dmem_ack` outside MEM is ignored.

## Structure
- The shared package `definitions` gains the `op_code` enum (4 bits, values above), the `mc_state_t` enum and the HALT encoding as a function of RAW.
- One sub-module, `mc_alu`: combinational. Inputs are rs, rt, C in and op; outputs are result, C out and Z, all parametrised by DW.
- The register file is inline: an array of 2^RAW by DW.
- The FSM, PC and flags live in `mc_core`.

## Test plan
- Reset/start:
  - Release reset, expect `done`=0, `imem_addr`=0, state IDLE.
  - Pulse `start` with program {HALT}, expect `done`=1 two cycles later and `instr_count`=0.
- Carry chain, DW=8:
  - r0=0xFF, r1=0x01, ADC r1: expect r1=0x00, C=1, Z=1.
  - Then ADC r2 with r2=0: expect r2=0x00 (0+0xFF+1 wraps to 0x00), C=1.
  - Then CLR: expect C=0.
- Compare: with r0=5 and r3=5, SBB with f=1 on r3 gives Z=1 and r3 still 5. A following BZ r4 with r4=0xFE branches to PC-2.
- Memory latency: LD with ack delayed 1, 3 and 7 cycles. Expect `dmem_req` held exactly until ack, retirement 3/5/9 cycles after FETCH, and r0=`dmem_rdata`. ST must drive `dmem_we`=1 and `dmem_wdata`=r0.
- Mid-operation reset: assert reset while `dmem_req`=1. Expect `dmem_req`=0 in the same cycle, IDLE, and a late ack ignored.
- Loop/wrap: JMP r5 with r5=3 at PC 2 goes to PC 0xFFFF. A BNZ countdown loop of 10 iterations gives `instr_count` equal to the expected retirements.

Source files
------------

// File: rtl/mc_core_pkg.sv
// Shared definitions for the multi-cycle core: opcode set, FSM states and
// the HALT encoding, which depends on the register-address width.
package definitions;

  typedef enum logic [3:0] {
    OP_ADC = 4'h0,
    OP_SBB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_XOR = 4'h4,
    OP_SHL = 4'h5,
    OP_SHR = 4'h6,
    OP_MOV = 4'h7,
    OP_MVA = 4'h8,
    OP_CLR = 4'h9,
    OP_BZ  = 4'hA,
    OP_BNZ = 4'hB,
    OP_LD  = 4'hC,
    OP_ST  = 4'hD,
    OP_JMP = 4'hE,
    OP_NOP = 4'hF
  } op_code;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    MEM,
    HALTED
  } mc_state_t;

  // HALT is the all-ones instruction word of width 1+4+raw.
  function automatic logic [31:0] halt_instr(input int unsigned raw);
    return (32'd1 << (raw + 32'd5)) - 32'd1;
  endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU for the multi-cycle core; rs is always the accumulator r0.
module mc_alu
  import definitions::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic [DW-1:0] rs,
  input  logic [DW-1:0] rt,
  input  logic          c_in,
  input  op_code        op,
  output logic [DW-1:0] result,
  output logic          c_out,
  output logic          z
);

  logic [DW:0] sum;
  logic [DW:0] diff;

  assign sum  = {1'b0, rt} + {1'b0, rs} + {{DW{1'b0}}, c_in};
  // Bit DW of the difference is the borrow out.
  assign diff = {1'b0, rt} - {1'b0, rs} - {{DW{1'b0}}, c_in};

  always_comb begin
    result = rt;
    c_out  = c_in;
    case (op)
      OP_ADC: {c_out, result} = sum;
      OP_SBB: {c_out, result} = diff;
      OP_AND: result = rt & rs;
      OP_OR:  result = rt | rs;
      OP_XOR: result = rt ^ rs;
      OP_SHL: begin
        result = {rt[DW-2:0], 1'b0};
        c_out  = rt[DW-1];
      end
      OP_SHR: begin
        result = {1'b0, rt[DW-1:1]};
        c_out  = rt[0];
      end
      OP_MOV: result = rs;
      OP_MVA: result = rt;
      default: ;
    endcase
    z = (result == '0);
  end

endmodule

// File: rtl/mc_core.sv
// Multi-cycle accumulator core: fetch/execute/memory FSM, PC, flags and an
// inline register file; data memory is reached through a req/ack handshake.
module mc_core
  import definitions::*;
#(
  parameter  int unsigned DW  = 8,
  parameter  int unsigned RAW = 4,
  parameter  int unsigned PCW = 16,
  localparam int unsigned IW  = 1 + 4 + RAW
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic [PCW-1:0] imem_addr,
  input  logic [IW-1:0]  imem_data,
  output logic           dmem_req,
  output logic           dmem_we,
  output logic [DW-1:0]  dmem_addr,
  output logic [DW-1:0]  dmem_wdata,
  input  logic [DW-1:0]  dmem_rdata,
  input  logic           dmem_ack,
  output logic           done,
  output logic [31:0]    instr_count
);

  localparam int unsigned   NREG = 2 ** RAW;
  localparam logic [IW-1:0] HALT = IW'(halt_instr(RAW));

  mc_state_t       state, state_next;
  logic [PCW-1:0]  pc;
  logic [IW-1:0]   ir;
  logic [DW-1:0]   regs [NREG];
  logic            c_flag, z_flag;

  logic            f;
  op_code          op;
  logic [RAW-1:0]  rt;
  logic [DW-1:0]   r0, rt_val, alu_result;
  logic            alu_c, alu_z;
  logic            is_halt, is_mem, retire;

  assign f       = ir[IW-1];
  assign op      = op_code'(ir[IW-2:RAW]);
  assign rt      = ir[RAW-1:0];
  assign r0      = regs[0];
  assign rt_val  = regs[rt];
  assign is_halt = (ir == HALT);
  assign is_mem  = (op == OP_LD) || (op == OP_ST);

  assign imem_addr = pc;
  assign done      = (state == HALTED);

  mc_alu #(.DW(DW)) u_alu (
    .rs     (r0),
    .rt     (rt_val),
    .c_in   (c_flag),
    .op     (op),
    .result (alu_result),
    .c_out  (alu_c),
    .z      (alu_z)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    retire     = 1'b0;
    case (state)
      IDLE, HALTED: if (start) state_next = FETCH;
      FETCH:        state_next = EXEC;
      EXEC: begin
        if (is_halt) begin
          state_next = HALTED;
        end else if (is_mem) begin
          state_next = MEM;
        end else begin
          state_next = FETCH;
          retire     = 1'b1;
        end
      end
      MEM: begin
        if (dmem_ack) begin
          state_next = FETCH;
          retire     = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= '0;
      ir          <= '0;
      c_flag      <= 1'b0;
      z_flag      <= 1'b0;
      instr_count <= '0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (retire && (instr_count != '1)) instr_count <= instr_count + 32'd1;
      case (state)
        IDLE, HALTED: begin
          if (start) begin
            pc          <= '0;
            c_flag      <= 1'b0;
            z_flag      <= 1'b0;
            instr_count <= '0;
          end
        end
        FETCH: ir <= imem_data;
        EXEC: begin
          if (!is_halt) begin
            // Default successor; branches and JMP override it below.
            pc <= pc + PCW'(1);
            case (op)
              OP_ADC, OP_SBB, OP_AND, OP_OR, OP_XOR,
              OP_SHL, OP_SHR, OP_MOV, OP_MVA: begin
                c_flag <= alu_c;
                z_flag <= alu_z;
                if (!f) begin
                  if (op == OP_MVA) regs[0]  <= alu_result;
                  else              regs[rt] <= alu_result;
                end
              end
              OP_CLR: c_flag <= 1'b0;
              OP_BZ:  if (z_flag)  pc <= pc + PCW'($signed(rt_val));
              OP_BNZ: if (!z_flag) pc <= pc + PCW'($signed(rt_val));
              OP_LD, OP_ST: begin
                dmem_req   <= 1'b1;
                dmem_we    <= (op == OP_ST);
                dmem_addr  <= rt_val;
                dmem_wdata <= r0;
              end
              OP_JMP: pc <= pc - PCW'(rt_val);
              default: ;
            endcase
          end
        end
        MEM: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (!dmem_we) regs[0] <= dmem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
